// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - nic8 fetch stage bus: ROM, data bus, decoder controls and fetch outputs
interface fetch_sequencer_if;
    logic [7:0]  romData;
    logic [7:0]  dataBus;
    logic        doJump;
    logic        assertRom;
    logic        runMode;
    logic        step;
    logic [7:0]  pc;
    logic [7:0]  ir;
    logic        execEnable;
    logic        fetching;
    logic [15:0] instrCount;

    modport master (
        output romData, dataBus, doJump, assertRom, runMode, step,
        input  pc, ir, execEnable, fetching, instrCount
    );

    modport slave (
        input  romData, dataBus, doJump, assertRom, runMode, step,
        output pc, ir, execEnable, fetching, instrCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - nic8 instruction fetch and program counter stage
module fetch_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.slave  bus
);

    // One-hot so that fetching/execEnable are direct flop outputs
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        FETCH = 3'b010,
        EXEC  = 3'b100
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [15:0] instr_count_q, instr_count_d;
    logic        step_prev_q, step_prev_d;
    logic        step_edge;

    assign step_edge = bus.step & ~step_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= 8'h00;
            instr_count_q <= 16'h0000;
            step_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            instr_count_q <= instr_count_d;
            step_prev_q   <= step_prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.runMode || step_edge) state_d = FETCH;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = bus.runMode ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Jump beats immediate consume; decoder controls only matter in EXEC
    always_comb begin
        pc_d          = pc_q;
        ir_d          = ir_q;
        instr_count_d = instr_count_q;
        step_prev_d   = bus.step;
        case (state_q)
            FETCH: begin
                ir_d = bus.romData;
                pc_d = pc_q + 8'd1;
            end
            EXEC: begin
                if (bus.doJump) begin
                    pc_d = bus.dataBus;
                end else if (bus.assertRom) begin
                    pc_d = pc_q + 8'd1;
                end
                instr_count_d = instr_count_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.pc         = pc_q;
        bus.ir         = ir_q;
        bus.instrCount = instr_count_q;
        bus.fetching   = state_q[1];
        bus.execEnable = state_q[2];
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed bench for fetch_sequencer against a cycle model
module tb_fetch_sequencer;

    localparam logic [7:0] RST_PC = 8'h00;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] rom [256];

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.romData = rom[bus.pc];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = idle, 1 = fetch, 2 = exec
    int m_phase, m_pc, m_ir, m_cnt, m_sp;
    bit m_valid = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_nop();
        bus.doJump    = 1'b0;
        bus.assertRom = 1'b0;
        bus.dataBus   = 8'h00;
        bus.step      = 1'b0;
    endtask

    // Compare outputs with the model, apply current inputs to the model, advance one clock
    task automatic cycle();
        int n_phase, n_pc, n_ir, n_cnt, n_sp;
        bit se;
        if (m_valid) begin
            check("pc", bus.pc, m_pc);
            check("ir", bus.ir, m_ir);
            check("fetching", bus.fetching, (m_phase == 1));
            check("execEnable", bus.execEnable, (m_phase == 2));
            check("instrCount", bus.instrCount, m_cnt);
        end
        n_phase = m_phase; n_pc = m_pc; n_ir = m_ir; n_cnt = m_cnt;
        n_sp = bus.step;
        if (reset) begin
            n_phase = 0; n_pc = RST_PC; n_ir = 0; n_cnt = 0; n_sp = 0;
        end else begin
            se = bus.step && !m_sp;
            if (m_phase == 0) begin
                if (bus.runMode || se) n_phase = 1;
            end else if (m_phase == 1) begin
                n_ir = rom[m_pc];
                n_pc = (m_pc + 1) % 256;
                n_phase = 2;
            end else begin
                if (bus.doJump) n_pc = bus.dataBus;
                else if (bus.assertRom) n_pc = (m_pc + 1) % 256;
                n_cnt = (m_cnt + 1) % 65536;
                n_phase = bus.runMode ? 1 : 0;
            end
        end
        @(posedge clk);
        if (reset) m_valid = 1;
        m_phase = n_phase; m_pc = n_pc; m_ir = n_ir; m_cnt = n_cnt; m_sp = n_sp;
        @(negedge clk);
    endtask

    task automatic run_to_fetch(input int addr);
        int n = 0;
        set_nop();
        bus.runMode = 1'b1;
        while (!(bus.fetching && bus.pc == addr) && n < 600) begin
            cycle();
            n++;
        end
        check("reach_fetch", (n < 600), 1);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        reset = 1'b1;
        bus.runMode = 1'b1;
        set_nop();
        @(negedge clk);

        // Reset held 2 cycles, then free-run NOPs
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_pc", bus.pc, RST_PC);
        check("rst_ir", bus.ir, 0);
        check("rst_fetching", bus.fetching, 0);
        check("rst_exec", bus.execEnable, 0);
        check("rst_count", bus.instrCount, 0);
        for (int i = 0; i < 9; i++) begin
            check("fr_pc", bus.pc, i / 2);
            check("fr_exec", bus.execEnable, (i >= 2 && i % 2 == 0));
            cycle();
        end
        check("fr_count4", bus.instrCount, 4);

        // Jump from ROM[03], alone and with assertRom also high
        for (int a = 0; a < 2; a++) begin
            run_to_fetch(3);
            cycle();
            bus.doJump = 1'b1; bus.assertRom = 1'(a); bus.dataBus = 8'h40;
            cycle();
            set_nop();
            check("jump_pc", bus.pc, 8'h40);
            check("jump_fetching", bus.fetching, 1);
            cycle();
            check("jump_ir", bus.ir, rom[8'h40]);
        end

        // Immediate consume in EXEC at pc 05
        run_to_fetch(4);
        cycle();
        check("imm_exec_pc", bus.pc, 8'h05);
        bus.assertRom = 1'b1;
        cycle();
        set_nop();
        check("imm_pc", bus.pc, 8'h06);
        cycle();
        check("imm_ir", bus.ir, rom[8'h06]);

        // PC wrap in FETCH
        run_to_fetch(8'hFF);
        cycle();
        check("wrap_pc", bus.pc, 8'h00);
        check("wrap_exec", bus.execEnable, 1);

        // Single step: park in idle, then two step pulses
        bus.runMode = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        c0 = m_cnt;
        for (int p = 1; p <= 2; p++) begin
            bus.step = 1'b1;
            for (int i = 0; i < 10; i++) cycle();
            check("step_count", bus.instrCount, (c0 + p) % 65536);
            check("step_idle_f", bus.fetching, 0);
            check("step_idle_e", bus.execEnable, 0);
            bus.step = 1'b0;
            for (int i = 0; i < 3; i++) cycle();
        end

        // Reset in the middle of a jumping EXEC
        run_to_fetch(8'h20);
        cycle();
        bus.doJump = 1'b1; bus.dataBus = 8'h77; reset = 1'b1;
        cycle();
        reset = 1'b0;
        set_nop();
        check("mid_rst_pc", bus.pc, RST_PC);
        check("mid_rst_ir", bus.ir, 0);
        check("mid_rst_count", bus.instrCount, 0);
        check("mid_rst_idle", {bus.fetching, bus.execEnable}, 2'b00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) bus.runMode = ~bus.runMode;
            if ($urandom_range(0, 3) == 0) bus.step = ~bus.step;
            bus.doJump    = ($urandom_range(0, 3) == 0);
            bus.assertRom = ($urandom_range(0, 2) == 0);
            bus.dataBus   = 8'($urandom);
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
